// File: rtl/pulse_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_decoder_pkg
// Brief    : Shared types, widths and the one-hot decode helper for the
//            pulse_decoder block.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_decoder_pkg;

    // Hold counter width; covers hold lengths up to 255 cycles.
    localparam int CNT_W = 8;

    // Decoder FSM: idle (outputs low) or holding a captured code.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // 2-bit code to 4-bit one-hot vector; bit N set when code == N.
    function automatic logic [3:0] onehot_decode(input logic [1:0] code);
        onehot_decode = 4'b0001 << code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_decoder_hold_counter.sv
`default_nettype none
// ============================================================================
// Module   : hold_counter
// Brief    : Loadable 8-bit down-counter used to time the output hold.
//            Load has priority over decrement; last flags a count of one.
// Revision : 1.0 - initial release
// ============================================================================
module hold_counter
    import pulse_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] r_count;

    // Counter register: load wins over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count = r_count;
    assign last  = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pulse_decoder
// Brief    : Sequential 2-to-4 decoder. Captures a valid 2-bit code and
//            holds the matching one-hot output for HOLD cycles, allowing
//            gap-free back-to-back codes. Dropped codes raise ovr.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_decoder
    import pulse_decoder_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i0,
    input  logic i1,
    input  logic v,
    output logic rdy,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic busy,
    output logic ovr
);

    state_t           r_state;
    logic [1:0]       r_code;
    logic [3:0]       r_y;
    logic             r_busy;
    logic             r_ovr;

    logic             w_rdy;
    logic             w_accept;
    logic             w_last;
    logic             w_dec;
    logic [CNT_W-1:0] w_count;

    // Ready is a pure decode of registered state: idle, or final hold cycle.
    assign w_rdy    = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && w_last);
    assign w_accept = v && w_rdy;

    // Count down only while holding; a zero count is never decremented.
    assign w_dec = (r_state == ST_HOLD) && !w_accept && (w_count != '0);

    hold_counter u_hold_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_accept),
        .load_val (CNT_W'(HOLD)),
        .dec      (w_dec),
        .count    (w_count),
        .last     (w_last)
    );

    // Decoder FSM with registered one-hot outputs and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_code  <= 2'b00;
            r_y     <= 4'b0000;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_HOLD;
                        r_code  <= {i1, i0};
                        r_y     <= onehot_decode({i1, i0});
                        r_busy  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_last) begin
                        if (w_accept) begin
                            r_code <= {i1, i0};
                            r_y    <= onehot_decode({i1, i0});
                        end else begin
                            r_state <= ST_IDLE;
                            r_y     <= 4'b0000;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_y     <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Overrun pulse: a valid code arrived while the block was not ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else begin
            r_ovr <= v && !w_rdy;
        end
    end

    assign rdy  = w_rdy;
    assign y0   = r_y[0];
    assign y1   = r_y[1];
    assign y2   = r_y[2];
    assign y3   = r_y[3];
    assign busy = r_busy;
    assign ovr  = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_decoder
// Brief    : Scoreboard bench for pulse_decoder, HOLD=4 and HOLD=1 instances
//            driven by the same stimulus. A timeline model predicts outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_decoder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       i0    = 1'b0;
    logic       i1    = 1'b0;
    logic       v     = 1'b0;

    logic       rdy4, busy4, ovr4;
    logic [3:0] y4;
    logic       rdy1, busy1, ovr1;
    logic [3:0] y1;

    pulse_decoder #(.HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .v(v),
        .rdy(rdy4), .y0(y4[0]), .y1(y4[1]), .y2(y4[2]), .y3(y4[3]),
        .busy(busy4), .ovr(ovr4)
    );

    pulse_decoder #(.HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i0(i0), .i1(i1), .v(v),
        .rdy(rdy1), .y0(y1[0]), .y1(y1[1]), .y2(y1[2]), .y3(y1[3]),
        .busy(busy1), .ovr(ovr1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] y;
        logic       busy;
        logic       rdy;
        logic       ovr;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    // Timeline model: edge counter, edge of the latest accept, its code.
    int         e = 0;
    int         acc[2];
    logic [1:0] mcode[2];

    function automatic int hold_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Ready after edge n: the latest hold has reached its final cycle or ended.
    function automatic bit model_rdy(input int d, input int n);
        return n >= acc[d] + hold_of(d) - 1;
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got y/busy/rdy/ovr=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge with the sampled inputs; queue expectations.
    task automatic model_edge(input logic vs, input logic [1:0] cs);
        exp_t ex;
        bit   rp;
        e++;
        for (int d = 0; d < 2; d++) begin
            rp     = model_rdy(d, e - 1);
            ex.ovr = vs && !rp;
            if (vs && rp) begin
                acc[d]   = e;
                mcode[d] = cs;
            end
            ex.busy = (e < acc[d] + hold_of(d));
            ex.y    = ex.busy ? (4'b0001 << mcode[d]) : 4'b0000;
            ex.rdy  = model_rdy(d, e);
            if (d == 0) q4.push_back(ex);
            else        q1.push_back(ex);
        end
    endtask

    task automatic step(input logic vv, input logic [1:0] cc);
        @(negedge clk);
        v      = vv;
        {i1, i0} = cc;
        @(posedge clk);
        model_edge(vv, cc);
    endtask

    // Assert reset between edges, check the asynchronous clear, then release.
    task automatic do_reset();
        @(negedge clk);
        v     = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset4", {y4, busy4, rdy4, ovr4}, 7'b0000_0_1_0);
        check("reset1", {y1, busy1, rdy1, ovr1}, 7'b0000_0_1_0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        acc[0] = -1000;
        acc[1] = -1000;
    endtask

    // Monitor: compare whatever the DUTs present against queued expectations.
    always @(posedge clk) begin
        exp_t ex;
        #1;
        if (v === 1'b1 && $isunknown({i1, i0})) begin
            errors++;
            $display("FAIL protocol: v high with unknown code %b", {i1, i0});
        end
        if (q4.size() > 0) begin
            ex = q4.pop_front();
            check("hold4", {y4, busy4, rdy4, ovr4}, ex);
        end
        if (q1.size() > 0) begin
            ex = q1.pop_front();
            check("hold1", {y1, busy1, rdy1, ovr1}, ex);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] seq[3];
        int         idx;

        acc[0]   = -1000;
        acc[1]   = -1000;
        mcode[0] = 2'b00;
        mcode[1] = 2'b00;

        // Power-on reset state, before any clock edge.
        #1;
        check("por4", {y4, busy4, rdy4, ovr4}, 7'b0000_0_1_0);
        check("por1", {y1, busy1, rdy1, ovr1}, 7'b0000_0_1_0);
        do_reset();

        // Single code 2, then idle.
        step(1'b1, 2'd2);
        repeat (6) step(1'b0, 2'd0);

        // Every code in turn with gaps.
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 2'(c));
            repeat (5) step(1'b0, 2'd0);
        end

        // Codes 1,3,3 each offered as soon as the HOLD=4 instance is ready.
        seq[0] = 2'd1; seq[1] = 2'd3; seq[2] = 2'd3;
        idx = 0;
        for (int n = 0; n < 40 && idx < 3; n++) begin
            if (model_rdy(0, e)) begin
                step(1'b1, seq[idx]);
                idx++;
            end else begin
                step(1'b0, 2'd0);
            end
        end
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL b2b_issue: issued %0d codes, required 3", idx);
        end
        repeat (10) step(1'b0, 2'd0);

        // Overrun: code 0 offered two cycles into a hold of code 1.
        step(1'b1, 2'd1);
        step(1'b0, 2'd0);
        step(1'b1, 2'd0);
        repeat (6) step(1'b0, 2'd0);

        // Reset in the middle of a hold.
        step(1'b1, 2'd2);
        step(1'b0, 2'd0);
        do_reset();
        step(1'b1, 2'd3);
        repeat (6) step(1'b0, 2'd0);

        // v held high across codes 0..3.
        for (int c = 0; c < 4; c++) step(1'b1, 2'(c));
        repeat (6) step(1'b0, 2'd0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        repeat (8) step(1'b0, 2'd0);

        @(posedge clk);
        #2;
        checks++;
        if (q4.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: queue sizes %0d/%0d, required 0/0", q4.size(), q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
